uart_tx_buffer: RTL and testbench



---
 rtl/uart_tx_buffer.sv | 94 +++++++++
 tb/tb_uart_tx_buffer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: bus-fed byte FIFO draining into the uart sendData/sendReq/ready handshake; UART_TXBUF_IRQ_EN adds a low-water irq.
module uart_tx_buffer #(
  parameter int DEPTH = 16,
  parameter int LOW_WATER = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  addr_in,
  input  logic [31:0] wdata,
  input  logic        req,
  input  logic        we,
  output logic [31:0] rdata,
  output logic [7:0]  uart_send_data,
  output logic        uart_send_req,
  input  logic        uart_ready,
  output logic        irq_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_LOW, WAIT_HIGH} state_t;
  state_t state, state_nx;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic overflow, irq_en, wr_fifo, wr_ctrl, flush, full, pop, push, unused;
  logic [8:0] cnt9;
  logic [7:0] cnt8;
  assign wr_fifo = req & we & (addr_in == 4'h0);
  assign wr_ctrl = req & we & (addr_in == 4'h4);
  assign flush = wr_ctrl & wdata[0];
  assign full = count == FULL;
  assign pop = (state == IDLE) & (count != '0) & uart_ready;
  assign push = wr_fifo & ~flush & (~full | pop);
  assign uart_send_req = state == SEND;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = pop ? SEND : IDLE;
      SEND:      state_nx = WAIT_LOW;
      WAIT_LOW:  state_nx = uart_ready ? WAIT_LOW : WAIT_HIGH;
      WAIT_HIGH: state_nx = uart_ready ? IDLE : WAIT_HIGH;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (!resetn) uart_send_data <= 8'h00;
    else if (pop) uart_send_data <= mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata[7:0];
  end
  // flush clears the queue but leaves the FSM alone so an in-flight byte completes
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) overflow <= 1'b0;
    else if (wr_fifo & full & ~pop) overflow <= 1'b1;
    else if (wr_ctrl & wdata[2]) overflow <= 1'b0;
  end
  assign cnt9 = 9'(count);
  assign cnt8 = cnt9[8] ? 8'hff : cnt9[7:0];
  assign rdata = (addr_in == 4'h0) ? {16'h0, cnt8, 4'h0, overflow, (count == '0) & (state == IDLE) & uart_ready, count == '0, ~full} :
                 (addr_in == 4'h4) ? {30'h0, irq_en, 1'b0} : 32'h0;
`ifdef UART_TXBUF_IRQ_EN
  localparam logic [AW:0] LW = (AW+1)'(LOW_WATER);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      irq_en <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= wdata[1];
      irq_o <= irq_en & (count <= LW);
    end
  end
  assign unused = ^{wdata[31:8], wdata[3]};
`else
  assign irq_en = 1'b0;
  assign irq_o = 1'b0;
  assign unused = ^{wdata[31:8], wdata[3], wdata[1], LOW_WATER[0]};
`endif
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: randomized bench with a queue-based reference model and a busy-time uart model.
module tb_uart_tx_buffer;
  logic clk = 0, resetn = 0, req = 0, we = 0, uart_ready, irq_o, uart_send_req;
  logic [3:0] addr_in = 0;
  logic [31:0] wdata = 0, rdata;
  logic [7:0] uart_send_data;
  logic hold = 0, prev_req = 0;
  int busy = 0, tests = 0, fails = 0, tx_cnt = 0;
  logic [7:0] exp_q[$];
  logic ien;
  uart_tx_buffer dut (.clk(clk), .resetn(resetn), .addr_in(addr_in), .wdata(wdata), .req(req), .we(we),
    .rdata(rdata), .uart_send_data(uart_send_data), .uart_send_req(uart_send_req), .uart_ready(uart_ready), .irq_o(irq_o));
  always #5 clk = ~clk;
  assign uart_ready = !hold && busy == 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] st(input int cnt, input logic ovf, input logic idle);
    return {16'h0, 8'(cnt), 4'h0, ovf, idle, cnt == 0, cnt != 16};
  endfunction
  always @(negedge clk) begin
    if (uart_send_req) begin
      chk("req_ready", {31'h0, uart_ready}, 32'h1);
      chk("req_width", {31'h0, prev_req}, 32'h0);
      chk("tx_data", {24'h0, uart_send_data}, exp_q.size() != 0 ? {24'h0, exp_q.pop_front()} : 32'h100);
      tx_cnt++;
      busy = 10;
    end else if (busy > 0) busy--;
    prev_req = uart_send_req;
  end
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    req = 1; we = 1; addr_in = a; wdata = d;
    @(posedge clk); #1;
    req = 0; we = 0;
  endtask
  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    req = 1; we = 0; addr_in = a;
    #1 d = rdata;
    @(posedge clk); #1;
    req = 0;
  endtask
  task automatic push(input logic [7:0] b, input logic acc);
    wr(4'h0, {24'h0, b});
    if (acc) exp_q.push_back(b);
  endtask
  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (20) @(posedge clk);
    #1 chk("drain", exp_q.size(), 0);
  endtask
  logic [31:0] s;
  int t0, pc;
  initial begin
`ifdef UART_TXBUF_IRQ_EN
    ien = 1;
`else
    ien = 0;
`endif
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    rd(4'h0, s); chk("rst_status", s, 32'h7);
    chk("rst_irq", {31'h0, irq_o}, 32'h0);
    chk("rst_req", {31'h0, uart_send_req}, 32'h0);
    chk("rst_data", {24'h0, uart_send_data}, 32'h0);
    rd(4'h4, s); chk("rst_ctrl", s, 32'h0);
    rd(4'h8, s); chk("rst_hole", s, 32'h0);
    push(8'h41, 1); push(8'h42, 1); push(8'h43, 1);
    drain();
    chk("abc_cnt", tx_cnt, 3);
    rd(4'h0, s); chk("abc_status", s, 32'h7);
    hold = 1;
    for (int i = 0; i < 16; i++) push(8'(i), 0);
    rd(4'h0, s); chk("full_status", s, st(16, 0, 0));
    push(8'h10, 0);
    rd(4'h0, s); chk("ovf_status", s, st(16, 1, 0));
    wr(4'h4, 32'h4);
    rd(4'h0, s); chk("ovf_clear", s, st(16, 0, 0));
    wr(4'h4, 32'h1);
    rd(4'h0, s); chk("flush_full", s, st(0, 0, 0));
    t0 = tx_cnt;
    for (int i = 0; i < 16; i++) push(8'h60 + 8'(i), 1);
    hold = 0;
    push(8'hA5, 1);
    rd(4'h0, s); chk("pushpop_cnt", s, st(16, 0, 0));
    drain();
    chk("pushpop_tx", tx_cnt - t0, 17);
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i), 1);
    rd(4'h0, s); chk("pre_flush", s, st(5, 0, 0));
    wr(4'h4, 32'h1);
    exp_q.delete();
    rd(4'h0, s); chk("post_flush", s, st(0, 0, 0));
    t0 = tx_cnt;
    repeat (40) @(posedge clk);
    #1 chk("flush_notx", tx_cnt - t0, 0);
    rd(4'h0, s); chk("flush_idle", s, 32'h7);
    wr(4'h4, 32'h2);
    rd(4'h4, s); chk("ctrl_ien", s, {30'h0, ien, 1'b0});
    hold = 1;
    for (int i = 0; i < 6; i++) push(8'h20 + 8'(i), 1);
    hold = 0;
    for (int i = 0; i < 120; i++) begin
      if (i > 0) chk("irq_lw", {31'h0, irq_o}, {31'h0, ien && pc <= 2});
      rd(4'h0, s);
      pc = int'(s[15:8]);
    end
    chk("irq_drain", exp_q.size(), 0);
    wr(4'h4, 32'h0);
    @(posedge clk); #1;
    chk("irq_off", {31'h0, irq_o}, 32'h0);
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 9);
      if (r < 4 && exp_q.size() < 16) push(8'($urandom), 1);
      else if (r == 4) begin
        logic [3:0] a = 4'($urandom_range(5, 15));
        rd(a, s); chk("rnd_hole", s, 32'h0);
      end else if (r == 5 && !uart_send_req) begin
        hold = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
      end else begin
        @(posedge clk); #1;
      end
    end
    hold = 0;
    drain();
    rd(4'h0, s); chk("rnd_status", s, 32'h7);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
